// File: rtl/branch_predictor_pkg.sv
// Shared predictor definitions: 2-bit counter encodings, reset value and saturating update.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RST = CTR_WNT;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != CTR_ST) n = ctr_e'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// bp_btb: direct-mapped valid/tag/target store; one combinational lookup port,
// one synchronous write port (with its own tag compare), async clear on rst.
module bp_btb #(
  parameter int unsigned AW    = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TW    = AW - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TW-1:0]    rd_tag_i,
  output logic             rd_hit_o,
  output logic [AW-1:0]    rd_target_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TW-1:0]    wr_tag_i,
  input  logic             wr_target_en_i,
  input  logic [AW-1:0]    wr_target_i,
  output logic             wr_hit_o
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TW-1:0]    tag_q [DEPTH];
  logic [AW-1:0]    tgt_q [DEPTH];

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = tgt_q[rd_idx_i];
  assign wr_hit_o    = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

  // Valid/tag rewrite on a hit stores identical values, so allocate and hit share one path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      tag_q[wr_idx_i]   <= wr_tag_i;
      if (wr_target_en_i) tgt_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: BTB plus 2-bit counters, trained from EXE.
// Define BP_GSHARE_EN to move counters into a GHR-xor-indexed pattern table.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned memAddrWidth = 16,
  parameter int unsigned IDX_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [memAddrWidth-1:0] IF_pc,
  output logic                    BP_taken,
  output logic [memAddrWidth-1:0] BP_target_pc,
  input  logic                    E_En,
  input  logic                    E_Branch_taken,
  input  logic [memAddrWidth-1:0] EXE_pc,
  input  logic [memAddrWidth-1:0] EXE_target_pc,
  input  logic                    Stall_MA
);

  localparam int unsigned TW    = memAddrWidth - IDX_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [IDX_W-1:0]        if_idx, ex_idx, rd_ctr_idx, wr_ctr_idx;
  logic [TW-1:0]           if_tag, ex_tag;
  logic                    upd_en, if_hit, ex_hit;
  logic [memAddrWidth-1:0] btb_target;
  ctr_e                    ctr_q [DEPTH];
  ctr_e                    ctr_rd, ctr_wr;
  logic                    unused_pc_lsbs;

  assign if_idx         = IF_pc[IDX_W+1:2];
  assign if_tag         = IF_pc[memAddrWidth-1:IDX_W+2];
  assign ex_idx         = EXE_pc[IDX_W+1:2];
  assign ex_tag         = EXE_pc[memAddrWidth-1:IDX_W+2];
  assign upd_en         = E_En & ~Stall_MA;
  assign unused_pc_lsbs = ^{IF_pc[1:0], EXE_pc[1:0]};

  bp_btb #(
    .AW    (memAddrWidth),
    .IDX_W (IDX_W),
    .TW    (TW)
  ) u_btb (
    .clk            (clk),
    .rst            (rst),
    .rd_idx_i       (if_idx),
    .rd_tag_i       (if_tag),
    .rd_hit_o       (if_hit),
    .rd_target_o    (btb_target),
    .wr_en_i        (upd_en),
    .wr_idx_i       (ex_idx),
    .wr_tag_i       (ex_tag),
    .wr_target_en_i (~ex_hit | E_Branch_taken),
    .wr_target_i    (EXE_target_pc),
    .wr_hit_o       (ex_hit)
  );

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign rd_ctr_idx = if_idx ^ ghr_q;
  assign wr_ctr_idx = ex_idx ^ ghr_q;
  assign ctr_wr     = ctr_next(ctr_q[wr_ctr_idx], E_Branch_taken);
  assign ghr_d      = {ghr_q[IDX_W-2:0], E_Branch_taken};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ghr_q <= '0;
    else if (upd_en) ghr_q <= ghr_d;
  end
`else
  assign rd_ctr_idx = if_idx;
  assign wr_ctr_idx = ex_idx;
  // A miss reallocates the entry, so its counter restarts at the weak state of the outcome.
  assign ctr_wr     = ex_hit ? ctr_next(ctr_q[wr_ctr_idx], E_Branch_taken)
                             : (E_Branch_taken ? CTR_WT : CTR_WNT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
    end else if (upd_en) begin
      ctr_q[wr_ctr_idx] <= ctr_wr;
    end
  end

  assign ctr_rd       = ctr_q[rd_ctr_idx];
  assign BP_taken     = if_hit & ctr_rd[1];
  assign BP_target_pc = BP_taken ? btb_target : '0;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a table-level reference model predicts each
// lookup; a negedge monitor pops expectations and compares against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IF_pc, EXE_pc, EXE_target_pc;
  logic        E_En, E_Branch_taken, Stall_MA;
  logic        BP_taken;
  logic [15:0] BP_target_pc;

  branch_predictor #(.memAddrWidth(16), .IDX_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_pc          (IF_pc),
    .BP_taken       (BP_taken),
    .BP_target_pc   (BP_target_pc),
    .E_En           (E_En),
    .E_Branch_taken (E_Branch_taken),
    .EXE_pc         (EXE_pc),
    .EXE_target_pc  (EXE_target_pc),
    .Stall_MA       (Stall_MA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t;
    logic [15:0] tgt;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_pht   [16];
  int m_ghr;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1; m_pht[i] = 1;
    end
    m_ghr = 0;
  endfunction

  function automatic int sat(int c, bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic exp_t model_predict(int pc);
    exp_t e;
    int   idx, ctr;
    bit   hit;
    idx = (pc / 4) % 16;
    hit = m_valid[idx] && (m_tag[idx] == pc / 64);
`ifdef BP_GSHARE_EN
    ctr = m_pht[idx ^ m_ghr];
`else
    ctr = m_ctr[idx];
`endif
    e.t   = hit && (ctr >= 2);
    e.tgt = e.t ? 16'(m_tgt[idx]) : 16'h0000;
    return e;
  endfunction

  function automatic void model_update(int epc, bit t, int etgt);
    int idx;
    bit hit;
    idx = (epc / 4) % 16;
    hit = m_valid[idx] && (m_tag[idx] == epc / 64);
`ifdef BP_GSHARE_EN
    m_pht[idx ^ m_ghr] = sat(m_pht[idx ^ m_ghr], t);
    m_ghr = (m_ghr * 2 + int'(t)) % 16;
`else
    m_ctr[idx] = hit ? sat(m_ctr[idx], t) : (t ? 2 : 1);
`endif
    if (!hit) begin
      m_valid[idx] = 1; m_tag[idx] = epc / 64; m_tgt[idx] = etgt;
    end else if (t) begin
      m_tgt[idx] = etgt;
    end
  endfunction

  // Called at posedge+1: drive one cycle, predict its lookup, then apply the edge.
  task automatic step(input int pc, input bit en, input bit t, input int epc,
                      input int etgt, input bit stall);
    IF_pc = 16'(pc); E_En = en; E_Branch_taken = t;
    EXE_pc = 16'(epc); EXE_target_pc = 16'(etgt); Stall_MA = stall;
    sbq.push_back(model_predict(pc));
    @(posedge clk); #1;
    if (en && !stall) model_update(epc, t, etgt);
  endtask

  task automatic lookup(input int pc);
    step(pc, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input int lpc, input int epc, input bit t, input int etgt);
    step(lpc, 1, t, epc, etgt, 0);
  endtask

  // Reset with a pending update that must be discarded.
  task automatic do_reset(input int pc);
    exp_t z;
    z.t = 1'b0; z.tgt = 16'h0000;
    rst = 1'b1; IF_pc = 16'(pc); E_En = 1'b1; E_Branch_taken = 1'b1;
    EXE_pc = 16'(pc); EXE_target_pc = 16'h1234; Stall_MA = 1'b0;
    model_reset();
    sbq.push_back(z);
    @(posedge clk); #1;
    rst = 1'b0; E_En = 1'b0;
  endtask

  function automatic int rpc();
    return int'($urandom_range(0, 2)) * 64 + int'($urandom_range(0, 15)) * 4
         + int'($urandom_range(0, 3));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        if (BP_taken !== e.t || BP_target_pc !== e.tgt) begin
          miscompares++;
          $display("FAIL pred @%0t IF_pc=%h: got taken=%b target=%h, expected taken=%b target=%h",
                   $time, IF_pc, BP_taken, BP_target_pc, e.t, e.tgt);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b1; IF_pc = '0; E_En = 1'b0; E_Branch_taken = 1'b0;
    EXE_pc = '0; EXE_target_pc = '0; Stall_MA = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset(16'h0040);
    lookup(16'h0040);

    train(16'h0040, 16'h0040, 1, 16'h0100);   // same-cycle lookup sees pre-update state
    lookup(16'h0040);
    lookup(16'h0440);
    for (int i = 0; i < 4; i++) train(16'h0040, 16'h0040, 1, 16'h0100);
    train(16'h0040, 16'h0040, 0, 16'h0200);
    lookup(16'h0040);
    train(16'h0040, 16'h0040, 0, 16'h0200);
    lookup(16'h0040);

    for (int i = 0; i < 3; i++) step(16'h0080, 1, 1, 16'h0080, 16'h0300, 1);
    step(16'h0080, 1, 1, 16'h0080, 16'h0300, 0);
    lookup(16'h0080);
    train(16'h0080, 16'h0080, 0, 16'h0000);
    lookup(16'h0080);

    train(16'h0040, 16'h0040, 1, 16'h0100);
    train(16'h0040, 16'h0040, 1, 16'h0100);
    lookup(16'h0040);
    do_reset(16'h0040);
    lookup(16'h0040);

`ifdef BP_GSHARE_EN
    train(16'h0040, 16'h0040, 1, 16'h0500);
    lookup(16'h0040);
    for (int i = 0; i < 4; i++) train(16'h0040, 16'h0040, 0, 16'h0600);
    lookup(16'h0040);
`endif

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset(rpc());
      else step(rpc(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rpc(),
                int'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk); @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
